// File: rtl/slice_scheduler_pkg.sv
// Shared types and constants for the slice scheduler: FSM encoding and word geometry.
package slice_scheduler_pkg;

    localparam int WORD_W = 3;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/slice_scheduler_if.sv
// Requester/slicer-facing bundle of the slice scheduler.
interface slice_scheduler_if #(
    parameter int N_REQ = 4
);
    import slice_scheduler_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [WORD_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    ser_data;
    logic                    ser_sync;
    logic                    slice_res;
    logic                    done;
    logic [IDX_W-1:0]        done_id;
    logic                    done_odd;
    logic                    err;
    logic                    busy;

    modport master (
        output req, req_data, slice_res,
        input  gnt, ser_data, ser_sync, done, done_id, done_odd, err, busy
    );

    modport slave (
        input  req, req_data, slice_res,
        output gnt, ser_data, ser_sync, done, done_id, done_odd, err, busy
    );

endinterface

// File: rtl/slice_scheduler_arbiter.sv
// Round-robin picker: first requester strictly after the pointer wins, wrapping modulo N_REQ.
module rr_arbiter
    import slice_scheduler_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    int cand;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(pointer) + k) % N_REQ;
            if (!valid && req[cand]) begin
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slice_scheduler.sv
// Grants one requester at a time, shifts its 3-bit word MSB-first to the slicer,
// waits out the slicer latency and reports the odd-detect result.
module slice_scheduler
    import slice_scheduler_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int RESULT_LAT = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    slice_scheduler_if.slave bus
);

    localparam int WCNT_W = 3;

    state_t              state;
    logic [WORD_W-1:0]   word;
    logic [1:0]          bit_cnt;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [IDX_W-1:0]    pointer;
    logic [IDX_W-1:0]    cur_id;

    logic [N_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]    arb_index;
    logic                arb_valid;
    logic                take;
    logic [WORD_W-1:0]   granted_word;

    logic                ser_data_r;
    logic                ser_sync_r;
    logic                done_r;
    logic [IDX_W-1:0]    done_id_r;
    logic                done_odd_r;
    logic                err_r;
    logic                busy_r;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req),
        .pointer (pointer),
        .grant   (arb_grant),
        .index   (arb_index),
        .valid   (arb_valid)
    );

    // gnt must appear in the deciding cycle so a held req is acknowledged before it can repeat
    assign take         = reset_n && arb_valid && (state == IDLE || state == REPORT);
    assign granted_word = bus.req_data[int'(arb_index)*WORD_W +: WORD_W];

    assign bus.gnt      = take ? arb_grant : '0;
    assign bus.ser_data = ser_data_r;
    assign bus.ser_sync = ser_sync_r;
    assign bus.done     = done_r;
    assign bus.done_id  = done_id_r;
    assign bus.done_odd = done_odd_r;
    assign bus.err      = err_r;
    assign bus.busy     = busy_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            word       <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            pointer    <= IDX_W'(N_REQ - 1);
            cur_id     <= '0;
            ser_data_r <= 1'b0;
            ser_sync_r <= 1'b0;
            done_r     <= 1'b0;
            done_id_r  <= '0;
            done_odd_r <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ser_data_r <= 1'b0;
            ser_sync_r <= 1'b0;
            done_r     <= 1'b0;
            done_id_r  <= '0;
            done_odd_r <= 1'b0;
            case (state)
                IDLE, REPORT: begin
                    if (take) begin
                        word       <= granted_word;
                        cur_id     <= arb_index;
                        pointer    <= arb_index;
                        bit_cnt    <= 2'd2;
                        ser_data_r <= granted_word[WORD_W-1];
                        ser_sync_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state      <= SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == 2'd0) begin
                        wait_cnt <= WCNT_W'(RESULT_LAT - 1);
                        state    <= WAIT;
                    end else begin
                        bit_cnt    <= bit_cnt - 2'd1;
                        ser_data_r <= word[bit_cnt - 2'd1];
                    end
                end
                WAIT: begin
                    // result is registered here so done/err are already high in REPORT
                    if (wait_cnt == '0) begin
                        done_r     <= 1'b1;
                        done_id_r  <= cur_id;
                        done_odd_r <= bus.slice_res;
                        if (bus.slice_res != word[0]) begin
                            err_r <= 1'b1;
                        end
                        state <= REPORT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: transaction-level timeline model plus directed and random traffic.
module tb_slice_scheduler;

    localparam int N   = 4;
    localparam int RL  = 2;
    localparam int PER = 3 + RL + 1;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req_v   = '0;
    logic [3*N-1:0] data_v = '0;
    logic [N-1:0] keep    = '0;
    bit           rnd_mode = 1'b0;
    bit           faulty   = 1'b0;
    logic [7:0]   dl       = '0;
    logic [N-1:0] gnt_seen = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // timeline model state
    int last_g, free_at, g_at, busy_until;
    bit err_m;
    bit r_ser[64], r_sync[64], r_done[64], r_odd[64], r_errset[64];
    int r_id[64];

    // observation logs
    int gq_idx[$], gq_cyc[$], dq_id[$], dq_odd[$], dq_cyc[$], dq_err[$], wq[$];
    int cap, cap_n;

    int exp_b_idx[5] = '{0, 1, 2, 3, 0};
    int exp_b_odd[4] = '{1, 0, 1, 0};

    slice_scheduler_if #(.N_REQ(N)) ifc ();

    assign ifc.req       = req_v;
    assign ifc.req_data  = data_v;
    assign ifc.slice_res = faulty ? 1'b0 : dl[RL-1];

    slice_scheduler #(.N_REQ(N), .RESULT_LAT(RL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clock = ~clock;

    // slicer: the result is the serial stream delayed RL cycles, so the LSB lands RL cycles after it was sent
    always @(posedge clock) dl <= {dl[6:0], ifc.ser_data};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last_g = N - 1; free_at = 0; g_at = -1; busy_until = -1; err_m = 1'b0;
        for (int i = 0; i < 64; i++) begin
            r_ser[i] = 0; r_sync[i] = 0; r_done[i] = 0; r_odd[i] = 0; r_errset[i] = 0; r_id[i] = 0;
        end
    endtask

    always @(negedge clock) begin
        int s, d, win;
        logic [N-1:0] eg;
        logic [2:0] w;
        bit eb;
        gnt_seen = ifc.gnt;
        if (!reset_n) begin
            chk("reset_outputs", int'({ifc.gnt, ifc.done, ifc.done_id, ifc.done_odd, ifc.err,
                                       ifc.busy, ifc.ser_data, ifc.ser_sync}), 0);
            model_reset();
            cap_n = 0;
        end else begin
            s   = cyc % 64;
            eg  = '0;
            win = -1;
            eb  = (cyc > g_at) && (cyc <= busy_until);
            if (r_errset[s]) err_m = 1'b1;
            if (cyc >= free_at) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && ifc.req[(last_g + k) % N]) win = (last_g + k) % N;
                end
            end
            if (win >= 0) begin
                eg[win] = 1'b1;
                w = ifc.req_data[3*win +: 3];
                r_ser[(cyc+1)%64] = w[2];
                r_sync[(cyc+1)%64] = 1'b1;
                r_ser[(cyc+2)%64] = w[1];
                r_ser[(cyc+3)%64] = w[0];
                d = (cyc + PER) % 64;
                r_done[d]   = 1'b1;
                r_id[d]     = win;
                r_odd[d]    = faulty ? 1'b0 : w[0];
                r_errset[d] = faulty && w[0];
                last_g = win; g_at = cyc; free_at = cyc + PER; busy_until = cyc + PER;
            end
            chk("gnt", int'(ifc.gnt), int'(eg));
            chk("ser_data", int'(ifc.ser_data), int'(r_ser[s]));
            chk("ser_sync", int'(ifc.ser_sync), int'(r_sync[s]));
            chk("done", int'(ifc.done), int'(r_done[s]));
            chk("busy", int'(ifc.busy), int'(eb));
            chk("err", int'(ifc.err), int'(err_m));
            if (r_done[s]) begin
                chk("done_id", int'(ifc.done_id), r_id[s]);
                chk("done_odd", int'(ifc.done_odd), int'(r_odd[s]));
            end
            r_ser[s] = 0; r_sync[s] = 0; r_done[s] = 0; r_odd[s] = 0; r_errset[s] = 0; r_id[s] = 0;

            for (int i = 0; i < N; i++) begin
                if (ifc.gnt[i]) begin
                    gq_idx.push_back(i);
                    gq_cyc.push_back(cyc);
                end
            end
            if (ifc.done) begin
                dq_id.push_back(int'(ifc.done_id));
                dq_odd.push_back(int'(ifc.done_odd));
                dq_err.push_back(int'(ifc.err));
                dq_cyc.push_back(cyc);
            end
            if (ifc.ser_sync) begin
                cap = int'(ifc.ser_data); cap_n = 1;
            end else if (cap_n > 0 && cap_n < 3) begin
                cap = (cap << 1) | int'(ifc.ser_data);
                cap_n++;
                if (cap_n == 3) wq.push_back(cap);
            end
        end
        cyc++;
    end

    // one clock step; requesters react to last cycle's gnt
    task automatic cycle();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i]) begin
                if (!keep[i]) req_v[i] = 1'b0;
                else if (rnd_mode) data_v[3*i +: 3] = 3'($urandom);
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i]) begin
                    if ($urandom_range(7) == 0) begin
                        req_v[i] = 1'b1;
                        data_v[3*i +: 3] = 3'($urandom);
                        keep[i] = 1'($urandom);
                    end
                end else if (!gnt_seen[i] && $urandom_range(31) == 0) begin
                    req_v[i] = 1'b0;
                end
                if ($urandom_range(15) == 0) data_v[3*i +: 3] = 3'($urandom);
            end
        end
    endtask

    task automatic clear_logs();
        gq_idx.delete(); gq_cyc.delete(); dq_id.delete(); dq_odd.delete();
        dq_cyc.delete(); dq_err.delete(); wq.delete();
    endtask

    task automatic run_until_gnts(input int n, input int budget);
        for (int c = 0; c < budget && gq_idx.size() < n; c++) cycle();
        chk("gnt_count", gq_idx.size(), n);
    endtask

    task automatic run_until_dones(input int n, input int budget);
        for (int c = 0; c < budget && dq_id.size() < n; c++) cycle();
        chk("done_count", dq_id.size(), n);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_v = '0; keep = '0;
        cycle(); cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int n2g, n2d;
        model_reset();
        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;

        // single request, word 101
        clear_logs();
        data_v[2:0] = 3'b101; req_v[0] = 1'b1;
        run_until_dones(1, 20);
        chk("a_gnt_idx", gq_idx[0], 0);
        chk("a_word", wq[0], 5);
        chk("a_latency", dq_cyc[0] - gq_cyc[0], 6);
        chk("a_done_id", dq_id[0], 0);
        chk("a_done_odd", dq_odd[0], 1);
        chk("a_err", dq_err[0], 0);

        // all four held high from reset
        do_reset();
        clear_logs();
        data_v = {3'd6, 3'd5, 3'd4, 3'd3};
        keep = '1; req_v = '1;
        run_until_gnts(5, 60);
        req_v = '0; keep = '0;
        run_until_dones(5, 30);
        for (int k = 0; k < 5; k++) chk("b_gnt_order", gq_idx[k], exp_b_idx[k]);
        for (int k = 0; k < 4; k++) chk("b_odd_seq", dq_odd[k], exp_b_odd[k]);
        for (int k = 0; k < 4; k++) chk("b_gnt_gap", gq_cyc[k+1] - gq_cyc[k], 6);

        // stuck-at-0 slicer, then a correct word
        clear_logs();
        faulty = 1'b1;
        data_v[5:3] = 3'b111; req_v[1] = 1'b1;
        run_until_dones(1, 20);
        chk("c_odd", dq_odd[0], 0);
        chk("c_err_at_report", dq_err[0], 1);
        faulty = 1'b0;
        data_v[8:6] = 3'b011; req_v[2] = 1'b1;
        run_until_dones(2, 20);
        chk("c_odd_good", dq_odd[1], 1);
        chk("c_err_sticky", dq_err[1], 1);

        // reset during the second SHIFT cycle
        clear_logs();
        data_v[2:0] = 3'b110; req_v[0] = 1'b1;
        run_until_gnts(1, 20);
        cycle();
        reset_n = 1'b0;
        cycle(); cycle();
        reset_n = 1'b1;
        repeat (8) cycle();
        chk("d_no_done", dq_id.size(), 0);
        data_v[11:9] = 3'b011; req_v[3] = 1'b1;
        run_until_dones(1, 20);
        chk("d_done_id", dq_id[0], 3);
        chk("d_done_odd", dq_odd[0], 1);
        chk("d_word", wq[wq.size()-1], 3);

        // req[2] withdrawn while requester 1 is served
        clear_logs();
        data_v[5:3] = 3'b010; req_v[1] = 1'b1;
        run_until_gnts(1, 20);
        data_v[8:6] = 3'b111; req_v[2] = 1'b1;
        cycle(); cycle();
        req_v[2] = 1'b0;
        run_until_dones(1, 20);
        repeat (10) cycle();
        n2g = 0; n2d = 0;
        foreach (gq_idx[k]) if (gq_idx[k] == 2) n2g++;
        foreach (dq_id[k]) if (dq_id[k] == 2) n2d++;
        chk("e_no_gnt2", n2g, 0);
        chk("e_no_done2", n2d, 0);
        chk("e_done_id", dq_id[0], 1);

        // word changed the cycle after its grant
        clear_logs();
        data_v[5:3] = 3'b001; req_v[1] = 1'b1;
        run_until_gnts(1, 20);
        data_v[5:3] = 3'b110;
        run_until_dones(1, 20);
        chk("f_word", wq[0], 1);
        chk("f_done_odd", dq_odd[0], 1);

        // random traffic
        do_reset();
        clear_logs();
        rnd_mode = 1'b1;
        repeat (3000) cycle();
        rnd_mode = 1'b0;
        req_v = '0; keep = '0;
        repeat (12) cycle();
        chk("r_activity", int'(dq_id.size() > 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 The module SHALL provide parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The module SHALL provide parameter RESULT_LAT, default 2, meaning the cycles from the last serial bit to a valid slicer result (1..7).
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: req  in  N_REQ  per-requester request, held high until granted.
REQ-007 Port: req_data  in  3*N_REQ  3-bit word of requester i at bits [3i+2:3i].
REQ-008 Port: gnt  out  N_REQ  one-hot single-cycle pulse; word accepted.
REQ-009 Port: ser_data  out  1  serial bit to slicer, MSB first.
REQ-010 Port: ser_sync  out  1  high during the MSB cycle of each word.
REQ-011 Port: slice_res  in  1  slicer odd-detect output.
REQ-012 Port: done  out  1  single-cycle pulse; result reported.
REQ-013 Port: done_id  out  3  requester index for the reported result.
REQ-014 Port: done_odd  out  1  sampled slice_res, valid with done.
REQ-015 Port: err  out  1  sticky: slicer result disagreed with the word's LSB.
REQ-016 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, WAIT, REPORT.
REQ-018 IDLE/REPORT with any req high SHALL grant, pulse gnt for the winner in that cycle, latch its word, load bit counter = 2, and enter SHIFT next cycle.
REQ-019 IDLE with no req SHALL stay in IDLE; REPORT with no req SHALL go to IDLE.
REQ-020 Arbitration SHALL be round-robin: search starts at index last_granted+1 modulo N_REQ; after reset the pointer SHALL make index 0 highest priority.
REQ-021 SHIFT SHALL drive ser_data = word[counter] for exactly 3 cycles (bits 2, 1, 0), with ser_sync high only while counter = 2.
REQ-022 After the counter = 0 cycle, SHIFT SHALL enter WAIT and load the wait counter with RESULT_LAT-1.
REQ-023 WAIT SHALL sample slice_res in the cycle its counter reaches 0, then enter REPORT.
REQ-024 REPORT SHALL pulse done for 1 cycle with done_id = granted index and done_odd = sampled slice_res.
REQ-025 If done_odd differs from word[0], err SHALL set in the REPORT cycle and hold until reset.
REQ-026 Back-to-back operation: a grant in REPORT SHALL put the next MSB on ser_data in the following cycle, giving a 3+RESULT_LAT+1 cycle period per word.
REQ-027 Outside SHIFT, ser_data and ser_sync SHALL be 0.
REQ-028 A req deasserted before its grant SHALL be ignored; a req still high in the cycle after its gnt SHALL count as a new request.
REQ-029 req_data of a granted requester SHALL be sampled only in the gnt cycle; later changes SHALL have no effect.
REQ-030 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-031 While reset_n is low: state = IDLE; gnt, done, done_id, done_odd, err, busy, ser_data, ser_sync = 0; RR pointer = N_REQ-1.
REQ-032 Reset asserted mid-word SHALL abort the word with no done pulse; after release the FSM SHALL start in IDLE.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=0, SHIFT=1, WAIT=2, REPORT=3) and the constant WORD_W = 3.
REQ-034 The round-robin picker SHALL be one sub-module, rr_arbiter (req, pointer -> one-hot grant, index); all sequencing SHALL stay in slice_scheduler.

Verification
REQ-035 Single request: req[0]=1, word 3'b101, slicer model with RESULT_LAT=2 -> ser_data 1,0,1 with ser_sync on the first bit; done pulses 6 cycles after gnt; done_id=0; done_odd=1; err=0.
REQ-036 All four requesters held high with words 3,4,5,6 -> gnt order 0,1,2,3,0; done_odd sequence 1,0,1,0; gap between gnt pulses = 6 cycles.
REQ-037 Faulty slicer that forces slice_res=0, word 3'b111 -> done_odd=0; err rises in the REPORT cycle and stays 1 across later correct words.
REQ-038 reset_n pulsed low during the second SHIFT cycle -> all outputs 0 immediately, no done pulse; a new request after release is served normally.
REQ-039 req[2] raised, then dropped before its grant while requester 1 is being served -> requester 2 is never granted and no done pulse carries done_id=2.
REQ-040 req_data of requester 1 changed from 3'b001 to 3'b110 the cycle after its gnt -> ser_data carries 0,0,1 and done_odd=1.
